// File: rtl/im_addr_sequencer.sv
// im_addr_sequencer: walks two strided address streams (A, B) into the
// item memory low-dim ports over valid/ready handshakes.
module im_addr_sequencer #(
  parameter int unsigned ImAddrWidth = 32,
  parameter int unsigned CountWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic [CountWidth-1:0]  cfg_num_items_i,
  input  logic [ImAddrWidth-1:0] cfg_a_base_i,
  input  logic [ImAddrWidth-1:0] cfg_a_stride_i,
  input  logic                   cfg_b_en_i,
  input  logic [ImAddrWidth-1:0] cfg_b_base_i,
  input  logic [ImAddrWidth-1:0] cfg_b_stride_i,
  output logic [ImAddrWidth-1:0] lowdim_a_data_o,
  output logic                   im_a_data_valid_o,
  input  logic                   im_a_data_ready_i,
  output logic [ImAddrWidth-1:0] lowdim_b_data_o,
  output logic                   im_b_data_valid_o,
  input  logic                   im_b_data_ready_i,
  output logic [CountWidth-1:0]  item_count_o
);

  typedef enum logic {Idle, Run} state_e;

  localparam logic [CountWidth-1:0] CntOne = CountWidth'(1);

  state_e state_q, state_d;

  logic [CountWidth-1:0]  num_q, num_d;
  logic [CountWidth-1:0]  a_cnt_q, a_cnt_d;
  logic [CountWidth-1:0]  b_cnt_q, b_cnt_d;
  logic [ImAddrWidth-1:0] a_stride_q, a_stride_d;
  logic [ImAddrWidth-1:0] b_stride_q, b_stride_d;
  logic [ImAddrWidth-1:0] a_addr_q, a_addr_d;
  logic [ImAddrWidth-1:0] b_addr_q, b_addr_d;
  logic                   a_valid_q, a_valid_d;
  logic                   b_valid_q, b_valid_d;
  logic                   done_q, done_d;

  logic                   a_hs, b_hs;
  logic [CountWidth-1:0]  a_cnt_inc, b_cnt_inc;

  assign a_hs      = a_valid_q & im_a_data_ready_i;
  assign b_hs      = b_valid_q & im_b_data_ready_i;
  assign a_cnt_inc = a_cnt_q + CntOne;
  assign b_cnt_inc = b_cnt_q + CntOne;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    a_cnt_d    = a_cnt_q;
    b_cnt_d    = b_cnt_q;
    a_stride_d = a_stride_q;
    b_stride_d = b_stride_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_valid_d  = a_valid_q;
    b_valid_d  = b_valid_q;
    done_d     = 1'b0;
    if (clr_i) begin
      state_d   = Idle;
      a_cnt_d   = '0;
      b_cnt_d   = '0;
      a_addr_d  = '0;
      b_addr_d  = '0;
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (start_i) begin
            num_d      = cfg_num_items_i;
            a_stride_d = cfg_a_stride_i;
            b_stride_d = cfg_b_stride_i;
            a_addr_d   = cfg_a_base_i;
            b_addr_d   = cfg_b_base_i;
            a_cnt_d    = '0;
            b_cnt_d    = '0;
            // Zero-length sequence completes without leaving Idle
            if (cfg_num_items_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d   = Run;
              a_valid_d = 1'b1;
              b_valid_d = cfg_b_en_i;
            end
          end
        end
        Run: begin
          if (a_hs) begin
            a_cnt_d   = a_cnt_inc;
            a_addr_d  = a_addr_q + a_stride_q;
            a_valid_d = a_cnt_inc < num_q;
          end
          if (b_hs) begin
            b_cnt_d   = b_cnt_inc;
            b_addr_d  = b_addr_q + b_stride_q;
            b_valid_d = b_cnt_inc < num_q;
          end
          if (!a_valid_d && !b_valid_d) begin
            state_d = Idle;
            done_d  = 1'b1;
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      num_q      <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      a_stride_q <= '0;
      b_stride_q <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      a_stride_q <= a_stride_d;
      b_stride_q <= b_stride_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy_o            = (state_q == Run);
  assign done_o            = done_q;
  assign lowdim_a_data_o   = a_addr_q;
  assign im_a_data_valid_o = a_valid_q;
  assign lowdim_b_data_o   = b_addr_q;
  assign im_b_data_valid_o = b_valid_q;
  assign item_count_o      = a_cnt_q;

endmodule

// File: tb/tb_im_addr_sequencer.sv
// tb_im_addr_sequencer: table vectors, directed corner sequences and
// randomized traffic checked against an index-based reference model.
module tb_im_addr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, start;
  logic        busy, done;
  logic [15:0] cfg_n;
  logic [31:0] abase, astr, bbase, bstr;
  logic        ben;
  logic [31:0] a_addr, b_addr;
  logic        va, vb, ra, rb;
  logic [15:0] cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  im_addr_sequencer dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .clr_i             (clr),
    .start_i           (start),
    .busy_o            (busy),
    .done_o            (done),
    .cfg_num_items_i   (cfg_n),
    .cfg_a_base_i      (abase),
    .cfg_a_stride_i    (astr),
    .cfg_b_en_i        (ben),
    .cfg_b_base_i      (bbase),
    .cfg_b_stride_i    (bstr),
    .lowdim_a_data_o   (a_addr),
    .im_a_data_valid_o (va),
    .im_a_data_ready_i (ra),
    .lowdim_b_data_o   (b_addr),
    .im_b_data_valid_o (vb),
    .im_b_data_ready_i (rb),
    .item_count_o      (cnt)
  );

  // Reference model: sequence position as plain indices
  bit          m_run, m_done, m_zero, m_ben;
  int          m_n, m_ia, m_ib;
  logic [31:0] m_abase, m_astr, m_bbase, m_bstr;

  function automatic logic [31:0] addr_at(logic [31:0] base,
                                          logic [31:0] stride,
                                          int idx);
    logic [31:0] k;
    k = idx;
    return base + k * stride;
  endfunction

  function automatic bit m_va();
    return m_run && (m_ia < m_n);
  endfunction

  function automatic bit m_vb();
    return m_run && m_ben && (m_ib < m_n);
  endfunction

  task automatic model_reset();
    m_run  = 0; m_done = 0; m_zero = 1; m_ben = 0;
    m_n    = 0; m_ia   = 0; m_ib   = 0;
    m_abase = '0; m_astr = '0; m_bbase = '0; m_bstr = '0;
  endtask

  task automatic model_edge();
    bit ha, hb;
    ha = m_va() && ra;
    hb = m_vb() && rb;
    m_done = 0;
    if (clr) begin
      m_run = 0; m_ia = 0; m_ib = 0; m_zero = 1;
    end else if (!m_run) begin
      if (start) begin
        m_n = cfg_n; m_ben = ben;
        m_abase = abase; m_astr = astr;
        m_bbase = bbase; m_bstr = bstr;
        m_ia = 0; m_ib = 0; m_zero = 0;
        if (m_n == 0) m_done = 1;
        else m_run = 1;
      end
    end else begin
      if (ha) m_ia++;
      if (hb) m_ib++;
      if (m_ia >= m_n && (!m_ben || m_ib >= m_n)) begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic check_model();
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("valid_a", 32'(va), 32'(m_va()));
    chk("valid_b", 32'(vb), 32'(m_vb()));
    chk("item_count", 32'(cnt), 32'(m_ia));
    if (m_va()) chk("addr_a", a_addr, addr_at(m_abase, m_astr, m_ia));
    if (m_vb()) chk("addr_b", b_addr, addr_at(m_bbase, m_bstr, m_ib));
    if (m_zero) begin
      chk("addr_a_zero", a_addr, 32'h0);
      chk("addr_b_zero", b_addr, 32'h0);
    end
  endtask

  typedef struct {
    logic        clr, start, ra;
    logic [15:0] n;
    logic [31:0] base;
    logic        busy, done, va;
    logic [31:0] addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit seen;
    logic [31:0] qb[$];

    tbl[0]  = '{0, 1, 1, 4, 32'h10, 1, 0, 1, 32'h10, 0};
    tbl[1]  = '{0, 0, 1, 4, 32'h10, 1, 0, 1, 32'h11, 1};
    tbl[2]  = '{0, 0, 1, 4, 32'h10, 1, 0, 1, 32'h12, 2};
    tbl[3]  = '{0, 0, 1, 4, 32'h10, 1, 0, 1, 32'h13, 3};
    tbl[4]  = '{0, 0, 1, 4, 32'h10, 0, 1, 0, 32'h0, 4};
    tbl[5]  = '{0, 0, 1, 3, 32'hFFFF_FFFE, 0, 0, 0, 32'h0, 4};
    tbl[6]  = '{0, 1, 0, 3, 32'hFFFF_FFFE, 1, 0, 1, 32'hFFFF_FFFE, 0};
    tbl[7]  = '{0, 0, 0, 3, 32'h0, 1, 0, 1, 32'hFFFF_FFFE, 0};
    tbl[8]  = '{0, 0, 1, 3, 32'h0, 1, 0, 1, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{0, 0, 1, 3, 32'h0, 1, 0, 1, 32'h0000_0000, 2};
    tbl[10] = '{0, 0, 1, 3, 32'hFFFF_FFFE, 0, 1, 0, 32'h0, 3};
    tbl[11] = '{0, 1, 1, 3, 32'hFFFF_FFFE, 1, 0, 1, 32'hFFFF_FFFE, 0};
    tbl[12] = '{1, 0, 1, 3, 32'h0, 0, 0, 0, 32'h0, 0};
    tbl[13] = '{0, 0, 1, 3, 32'h0, 0, 0, 0, 32'h0, 0};

    rst_n = 0; clr = 0; start = 0; cfg_n = 0;
    abase = 0; astr = 0; bbase = 0; bstr = 0; ben = 0;
    ra = 0; rb = 0;
    model_reset();
    repeat (2) tick();
    check_model();
    @(negedge clk);
    rst_n = 1;

    // Table: basic A-only run, wrap-around, back-to-back start, clear
    astr = 1; ben = 0;
    for (int i = 0; i < 14; i++) begin
      clr = tbl[i].clr; start = tbl[i].start; ra = tbl[i].ra;
      cfg_n = tbl[i].n; abase = tbl[i].base;
      tick();
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("t%0d_va", i), 32'(va), 32'(tbl[i].va));
      chk($sformatf("t%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
      if (tbl[i].va) chk($sformatf("t%0d_addr", i), a_addr, tbl[i].addr);
    end
    clr = 0; start = 0;

    // Dual port, B backpressured on alternate cycles
    cfg_n = 3; abase = 0; astr = 2; ben = 1; bbase = 100; bstr = 1;
    ra = 1; rb = 0; start = 1;
    tick(); check_model();
    start = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      rb = c[0];
      if (vb && rb) qb.push_back(b_addr);
      tick(); check_model();
      seen = done;
    end
    chk("dual_done_seen", 32'(seen), 32'd1);
    chk("dual_b_count", 32'(qb.size()), 32'd3);
    for (int k = 0; k < qb.size() && k < 3; k++)
      chk($sformatf("dual_b%0d", k), qb[k], 32'd100 + 32'(k));
    rb = 1;

    // Zero-length start
    cfg_n = 0; ben = 1; start = 1;
    tick(); check_model();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_va", 32'(va), 32'd0);
    start = 0;
    tick(); check_model();
    chk("zero_done_clr", 32'(done), 32'd0);

    // Clear after three A transfers, then restart from base
    cfg_n = 8; abase = 32'h40; astr = 4; ben = 0; start = 1;
    tick(); check_model();
    start = 0;
    repeat (3) begin tick(); check_model(); end
    chk("clr_pre_cnt", 32'(cnt), 32'd3);
    clr = 1;
    tick(); check_model();
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_cnt", 32'(cnt), 32'd0);
    clr = 0; start = 1;
    tick(); check_model();
    chk("restart_addr", a_addr, 32'h40);
    start = 0;

    // Start in RUN with different cfg is ignored
    cfg_n = 2; abase = 32'h999; astr = 7; ben = 1; start = 1; ra = 0;
    repeat (2) begin tick(); check_model(); end
    ra = 1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick(); check_model();
      seen = done;
    end
    chk("ignore_done_seen", 32'(seen), 32'd1);
    chk("ignore_cnt", 32'(cnt), 32'd8);
    start = 0;

    // Async reset mid-run
    cfg_n = 5; abase = 32'h77; ben = 1; bbase = 5; start = 1;
    tick(); start = 0;
    tick(); check_model();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_va", 32'(va), 32'd0);
    chk("rst_vb", 32'(vb), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_addr_a", a_addr, 32'd0);
    chk("rst_addr_b", b_addr, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      clr   = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 3) == 0);
      cfg_n = 16'($urandom_range(0, 6));
      ben   = $urandom_range(0, 1);
      abase = $urandom;
      bbase = $urandom;
      astr  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      bstr  = $urandom;
      ra    = ($urandom_range(0, 3) != 0);
      rb    = ($urandom_range(0, 3) != 0);
      tick(); check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/im_addr_sequencer.md
# im_addr_sequencer

Programmable address sequencer that drives the low-dimensional address ports (A and B) of the item memory top block. On a start command it walks two configurable arithmetic address sequences and hands them over valid/ready handshakes. Port A typically carries item/symbol addresses and port B carries level or position addresses. It sits between the CSR file and the item memory, and replaces software-fed addresses for regular encoding loops.

## Interface
- ImAddrWidth, 32, width of generated addresses (matches item memory address ports)
- CountWidth, 16, width of item count configuration and counters

- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- clr_i  input  1  synchronous software clear; aborts any sequence
- start_i  input  1  start pulse; sampled only in IDLE
- busy_o  output  1  high while in RUN
- done_o  output  1  one-cycle pulse when a sequence completes
- cfg_num_items_i  input  CountWidth  number of addresses to issue per enabled port
- cfg_a_base_i  input  ImAddrWidth  first port A address
- cfg_a_stride_i  input  ImAddrWidth  port A increment per transfer
- cfg_b_en_i  input  1  enable port B sequence
- cfg_b_base_i  input  ImAddrWidth  first port B address
- cfg_b_stride_i  input  ImAddrWidth  port B increment per transfer
- lowdim_a_data_o  output  ImAddrWidth  port A address
- im_a_data_valid_o  output  1  port A valid
- im_a_data_ready_i  input  1  port A ready
- lowdim_b_data_o  output  ImAddrWidth  port B address
- im_b_data_valid_o  output  1  port B valid
- im_b_data_ready_i  input  1  port B ready
- item_count_o  output  CountWidth  completed port A transfers in current/last sequence

## Operation
- FSM states: IDLE, RUN.
- IDLE: valids low. On start_i:
  - latch all cfg_* inputs into internal registers;
  - zero both counters;
  - load address registers with the bases;
  - enter RUN.
- After the latch, cfg_* inputs are ignored until the next start.
- start_i with latched num_items = 0: no transfers occur. Stay IDLE, pulse done_o next cycle.
- RUN: the ports advance independently.
  - Port A valid while a_cnt < num_items.
  - Port B valid while b_en and b_cnt < num_items.
- Handshake = valid && ready. On a handshake the port's address register += stride, modulo 2^ImAddrWidth (wrap silently), and its counter increments.
- Address and valid are registered. Once valid is high, address and valid stay stable until the handshake (no retraction).
- Completion:
  - Completion occurs when port A has finished and port B has either finished or is disabled.
  - FSM returns to IDLE; done_o pulses for one cycle.
- start_i asserted in RUN is ignored.
- item_count_o = a_cnt. It holds its value in IDLE until the next start.
- clr_i (any state) has priority over start_i and handshakes:
  - next cycle is IDLE;
  - valids low, counters zero, address registers zero;
  - no done_o pulse.
- Reset: same state as clr.

## Timing
- Reset values: busy_o=0, done_o=0, both valids=0, both addresses=0, item_count_o=0.
- Start sampled at edge t. From cycle t+1: busy_o=1, valid(s)=1, address=base.
- Throughput: one transfer per port per cycle while ready is held high.
- If the last handshake occurs at edge e, then in cycle e+1: done_o=1, busy_o=0, valids=0.
- Zero-length start at edge t: done_o=1 in cycle t+1; busy_o stays 0.
- A new start is accepted in the same cycle done_o is high, since the FSM is already in IDLE.
- Minimum full sequence latency with ready always high: N transfers, then done N+1 cycles after start.

## Test plan
- Basic A only: base=0x10, stride=1, N=4, b_en=0, ready=1.
  - Expect A addresses 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
  - done_o in cycle 5 after start; item_count_o=4.
- Dual port with backpressure: A base=0, stride=2; B base=100, stride=1; N=3. Toggle ready_b on alternate cycles.
  - Expect A = 0, 2, 4 and B = 100, 101, 102, each address held while valid && !ready.
  - done_o one cycle after B's final handshake.
- Wrap-around: ImAddrWidth=32, base=0xFFFF_FFFE, stride=1, N=3 -> addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Zero length: N=0, start -> no valid ever high; done_o exactly one cycle later.
- Clear mid-run: N=8, clr_i after 3 A transfers.
  - Next cycle: IDLE, valids 0, item_count_o=0, no done_o.
  - A following start restarts from base.
- Start ignored in RUN, plus async reset:
  - start_i pulsed during RUN with different cfg -> sequence unaffected.
  - rst_ni asserted mid-run -> all outputs 0 immediately.
